// File: rtl/debug_dump_pkg.sv
// Shared types and constants for the debug-port dump controller.
package debug_dump_pkg;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_STEP_HI = 4'd1,
        S_STEP_LO = 4'd2,
        S_HDR     = 4'd3,
        S_SETTLE  = 4'd4,
        S_SAMPLE  = 4'd5,
        S_SEND    = 4'd6,
        S_CSUM    = 4'd7,
        S_FIN     = 4'd8
    } dump_state_t;

    localparam logic [7:0] HDR_BYTE     = 8'hA5;
    localparam int         TEST_SEL_BIT = 5;

    // Header + 4 bytes per word + checksum.
    function automatic int frame_len(input int num_regs, input int num_test);
        return 2 + 4 * (num_regs + num_test);
    endfunction

endpackage

// File: rtl/debug_step_gen.sv
// Single-step pulse generator: STEP_CYC cycles high, then STEP_CYC cycles low.
module debug_step_gen #(
    parameter int STEP_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_go,
    output logic o_step,
    output logic o_hi_last,
    output logic o_finished
);

    localparam int              CW       = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
    localparam logic [CW-1:0]   CNT_INIT = CW'(STEP_CYC - 1);
    localparam logic [1:0]      PH_IDLE  = 2'd0;
    localparam logic [1:0]      PH_HI    = 2'd1;
    localparam logic [1:0]      PH_LO    = 2'd2;

    logic [1:0]    r_phase;
    logic [CW-1:0] r_cnt;
    logic          r_step;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_phase <= PH_IDLE;
            r_cnt   <= '0;
            r_step  <= 1'b0;
        end else begin
            case (r_phase)
                PH_IDLE: begin
                    if (i_go) begin
                        r_phase <= PH_HI;
                        r_cnt   <= CNT_INIT;
                        r_step  <= 1'b1;
                    end
                end
                PH_HI: begin
                    if (r_cnt == '0) begin
                        r_phase <= PH_LO;
                        r_cnt   <= CNT_INIT;
                        r_step  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                PH_LO: begin
                    if (r_cnt == '0) r_phase <= PH_IDLE;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                default: r_phase <= PH_IDLE;
            endcase
        end
    end

    assign o_step     = r_step;
    assign o_hi_last  = (r_phase == PH_HI) && (r_cnt == '0);
    assign o_finished = (r_phase == PH_LO) && (r_cnt == '0);

endmodule

// File: rtl/debug_dump_ctrl.sv
// Debug-port host: optional single step, then register/test-signal sweep
// packed into a framed byte stream (A5, data words MSB first, XOR checksum).
//
// state    | meaning
// IDLE     | waiting for start/step_req; core may free-run
// STEP_HI  | debug_step high phase
// STEP_LO  | debug_step low phase
// HDR      | presenting header byte
// SETTLE   | debug_addr applied, waiting read latency
// SAMPLE   | capturing debug_data
// SEND     | emitting 4 data bytes
// CSUM     | emitting checksum byte
// FIN      | done pulse, frame counted
module debug_dump_ctrl
    import debug_dump_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int NUM_TEST = 32,
    parameter int READ_LAT = 1,
    parameter int STEP_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        step_req,
    input  logic        free_run,
    output logic        debug_en,
    output logic        debug_step,
    output logic [6:0]  debug_addr,
    input  logic [31:0] debug_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done,
    output logic [15:0] frame_cnt
);

    localparam logic [6:0] LAST_IDX    = 7'(NUM_REGS + NUM_TEST - 1);
    localparam logic [6:0] REG_WORDS   = 7'(NUM_REGS);
    localparam logic [6:0] TEST_BASE   = 7'(1 << TEST_SEL_BIT);
    localparam logic [2:0] SETTLE_INIT = 3'(READ_LAT - 1);

    dump_state_t r_state;
    dump_state_t w_state_nxt;

    logic        r_debug_en;
    logic [6:0]  r_debug_addr;
    logic        r_tx_valid;
    logic [7:0]  r_tx_data;
    logic        r_done;
    logic [15:0] r_frame_cnt;
    logic [6:0]  r_idx;
    logic [1:0]  r_byte;
    logic [2:0]  r_settle;
    logic [31:0] r_shift;
    logic [7:0]  r_csum;

    logic        w_xfer;
    logic        w_step_go;
    logic        w_step_hi_last;
    logic        w_step_finished;
    logic [6:0]  w_idx_nxt;
    logic [6:0]  w_addr_nxt;

    assign w_xfer    = r_tx_valid & tx_ready;
    assign w_step_go = (r_state == S_IDLE) & step_req;
    assign w_idx_nxt = r_idx + 7'd1;
    // Register words sit below the test-select bit, test words above it.
    assign w_addr_nxt = (w_idx_nxt < REG_WORDS) ? w_idx_nxt
                                                : (TEST_BASE + w_idx_nxt - REG_WORDS);

    debug_step_gen #(
        .STEP_CYC (STEP_CYC)
    ) u_step_gen (
        .clk        (clk),
        .rst        (rst),
        .i_go       (w_step_go),
        .o_step     (debug_step),
        .o_hi_last  (w_step_hi_last),
        .o_finished (w_step_finished)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (step_req)   w_state_nxt = S_STEP_HI;
                else if (start) w_state_nxt = S_HDR;
            end
            S_STEP_HI: if (w_step_hi_last)  w_state_nxt = S_STEP_LO;
            S_STEP_LO: if (w_step_finished) w_state_nxt = S_HDR;
            S_HDR:     if (w_xfer)          w_state_nxt = S_SETTLE;
            S_SETTLE:  if (r_settle == '0)  w_state_nxt = S_SAMPLE;
            S_SAMPLE:  w_state_nxt = S_SEND;
            S_SEND: begin
                if (w_xfer && (r_byte == 2'd3))
                    w_state_nxt = (r_idx == LAST_IDX) ? S_CSUM : S_SETTLE;
            end
            S_CSUM:    if (w_xfer) w_state_nxt = S_FIN;
            S_FIN:     w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_debug_en   <= 1'b1;
            r_debug_addr <= '0;
            r_tx_valid   <= 1'b0;
            r_tx_data    <= '0;
            r_done       <= 1'b0;
            r_frame_cnt  <= '0;
            r_idx        <= '0;
            r_byte       <= '0;
            r_settle     <= '0;
            r_shift      <= '0;
            r_csum       <= '0;
        end else begin
            r_state    <= w_state_nxt;
            // Uses the next state so the core is held from the first busy cycle.
            r_debug_en <= ~(free_run & (w_state_nxt == S_IDLE));
            r_done     <= 1'b0;
            case (r_state)
                S_IDLE, S_STEP_LO: begin
                    if (w_state_nxt == S_HDR) begin
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= HDR_BYTE;
                        r_csum     <= '0;
                    end
                end
                S_HDR: begin
                    if (w_xfer) begin
                        r_tx_valid   <= 1'b0;
                        r_idx        <= '0;
                        r_debug_addr <= '0;
                        r_settle     <= SETTLE_INIT;
                    end
                end
                S_SETTLE: begin
                    if (r_settle != '0) r_settle <= r_settle - 3'd1;
                end
                S_SAMPLE: begin
                    r_tx_valid <= 1'b1;
                    r_tx_data  <= debug_data[31:24];
                    r_shift    <= {debug_data[23:0], 8'h00};
                    r_byte     <= '0;
                end
                S_SEND: begin
                    if (w_xfer) begin
                        r_csum <= r_csum ^ r_tx_data;
                        if (r_byte == 2'd3) begin
                            if (r_idx == LAST_IDX) begin
                                r_tx_data <= r_csum ^ r_tx_data;
                            end else begin
                                r_tx_valid   <= 1'b0;
                                r_idx        <= w_idx_nxt;
                                r_debug_addr <= w_addr_nxt;
                                r_settle     <= SETTLE_INIT;
                            end
                        end else begin
                            r_byte    <= r_byte + 2'd1;
                            r_tx_data <= r_shift[31:24];
                            r_shift   <= {r_shift[23:0], 8'h00};
                        end
                    end
                end
                S_CSUM: begin
                    if (w_xfer) begin
                        r_tx_valid  <= 1'b0;
                        r_done      <= 1'b1;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign debug_en   = r_debug_en;
    assign debug_addr = r_debug_addr;
    assign tx_valid   = r_tx_valid;
    assign tx_data    = r_tx_data;
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign frame_cnt  = r_frame_cnt;

endmodule

// File: doc/debug_dump_ctrl.md
Name: debug_dump_ctrl

Overview:
- Host side of the core's debug port: drives debug_en, debug_step and debug_addr, and reads debug_data.
- On command, optionally single-steps the core, then sweeps the register-file and test-signal address spaces.
- Packs the sampled words into a framed byte stream on a valid/ready interface, which feeds the board UART transmitter.
- Sits at top level between the RV32 core and the serial link.

Parameters:
- NUM_REGS, 32, register-file words dumped: addr 0..NUM_REGS-1, addr[5]=0. Legal range 1..32.
- NUM_TEST, 32, test-signal words dumped: addr 32..32+NUM_TEST-1, addr[5]=1. Legal range 1..32.
- READ_LAT, 1, cycles from a debug_addr change to the debug_data capture. Legal range 1..7.
- STEP_CYC, 4, cycles debug_step is held high, then held low, per step.

Ports:
- clk  in  1  main clock
- rst  in  1  synchronous, active-low reset (0 = reset)
- start  in  1  pulse: dump one frame, no step
- step_req  in  1  pulse: single-step the core, then dump one frame
- free_run  in  1  1 = release the core (debug_en=0) while IDLE
- debug_en  out  1  core debug enable
- debug_step  out  1  core step clock
- debug_addr  out  7  debug address to the core
- debug_data  in  32  debug data from the core
- tx_valid  out  1  byte available
- tx_data  out  8  byte
- tx_ready  in  1  sink accepts the byte
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a frame completes
- frame_cnt  out  16  completed-frame counter

Behaviour:
- Reset values: debug_en=1, debug_step=0, debug_addr=0, tx_valid=0, tx_data=0, busy=0, done=0, frame_cnt=0; FSM enters IDLE.
- debug_en = ~(free_run & state==IDLE), registered. It is forced to 1 for the entire operation.
- FSM states: IDLE, STEP_HI, STEP_LO, HDR, SETTLE, SAMPLE, SEND, CSUM, FIN.
- IDLE:
  - step_req -> STEP_HI.
  - else start -> HDR.
  - step_req and start in the same cycle -> STEP_HI; start is absorbed.
  - start or step_req while busy is ignored, with no queuing.
- STEP_HI: debug_step=1 for exactly STEP_CYC cycles -> STEP_LO.
- STEP_LO: debug_step=0 for exactly STEP_CYC cycles -> HDR. Each step_req produces exactly one rising edge on debug_step.
- HDR: present byte 8'hA5; on acceptance -> SETTLE with word index 0.
- Address sequence: debug_addr = idx for idx < NUM_REGS, otherwise 32+(idx-NUM_REGS). debug_addr updates on entry to SETTLE.
- SETTLE: wait READ_LAT cycles -> SAMPLE.
- SAMPLE: capture debug_data into a 32-bit shift register (1 cycle) -> SEND.
- SEND:
  - Emit 4 bytes MSB first.
  - After the 4th accepted byte: if idx == NUM_REGS+NUM_TEST-1 -> CSUM, else idx++ -> SETTLE.
- CSUM: emit the XOR of all data bytes (header excluded) -> FIN.
- FIN: done=1 for one cycle; frame_cnt++ (wraps 0xFFFF->0) -> IDLE.
- Frame length: 2+4*(NUM_REGS+NUM_TEST) bytes; 258 at defaults.
- Handshake rules:
  - A byte transfers on a cycle with tx_valid & tx_ready.
  - tx_valid and tx_data stay stable until transfer.
  - tx_valid never deasserts without a transfer, except on reset.
  - A new byte may be presented the cycle after a transfer.
- Reset mid-frame: rst=0 at any edge aborts the frame. All outputs take reset values at that edge; frame_cnt is cleared and no done pulse is issued.
- Word index is 7 bits wide; checksum register is 8 bits.

Decomposition:
- Package debug_dump_pkg holds:
  - the state enum;
  - constants HDR_BYTE=8'hA5 and TEST_SEL_BIT=5;
  - the frame-length function of NUM_REGS/NUM_TEST.
- Sub-module debug_step_gen: STEP_CYC high/low pulse generator with go/finished handshake, instantiated once.

Test Plan:
- Reset: hold rst=0 for 2 cycles -> debug_en=1, debug_step=0, debug_addr=0, tx_valid=0, busy=0, frame_cnt=0.
- Plain dump: core model returns 32'h1000_0000|addr, tx_ready=1, pulse start.
  - Stream is A5, 10 00 00 00, 10 00 00 01, ..., 10 00 00 1F, 10 00 00 20, ..., 10 00 00 3F, then checksum 8'h00 (XOR of the data bytes).
  - 258 bytes total; done pulses once; frame_cnt=1; debug_step never toggles.
- Step: pulse step_req -> debug_step high exactly 4 cycles, then low 4 cycles, then header A5.
  - A core-model PC counter advances by exactly 1.
- Backpressure: tx_ready random at 50% -> byte stream identical to the plain dump.
  - tx_data unchanged on every cycle with tx_valid & ~tx_ready.
- Collisions:
  - start and step_req in the same cycle -> one step, then one frame.
  - start pulses while busy -> ignored; frame_cnt increments by 1 only.
- Mid-frame reset: rst=0 after byte 100 -> next edge tx_valid=0, busy=0, frame_cnt=0.
  - A subsequent start yields a complete 258-byte frame.
